// File: rtl/ast_width_upconverter_pkg.sv
// Shared defaults, channel/empty types and width helpers for the Avalon-ST width upconverter.
package ast_width_upconverter_pkg;

    localparam int DEF_DATA_IN_W  = 64;
    localparam int DEF_DATA_OUT_W = 128;
    localparam int DEF_CHANNEL_W  = 10;

    // $clog2 that never returns 0, so counters and empty fields keep at least one bit
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    localparam int DEF_EMPTY_IN_W  = clog2_min1(DEF_DATA_IN_W / 8);
    localparam int DEF_EMPTY_OUT_W = clog2_min1(DEF_DATA_OUT_W / 8);

    typedef logic [DEF_CHANNEL_W-1:0]   channel_t;
    typedef logic [DEF_EMPTY_IN_W-1:0]  empty_in_t;
    typedef logic [DEF_EMPTY_OUT_W-1:0] empty_out_t;

endpackage

// File: rtl/ast_width_upconverter_out_reg.sv
// Output holding register: loads a completed wide word and holds it until the sink takes it.
module ast_upconv_out_reg #(
    parameter int DATA_W    = 128,
    parameter int EMPTY_W   = 4,
    parameter int CHANNEL_W = 10
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 load,
    input  logic [DATA_W-1:0]    data,
    input  logic [EMPTY_W-1:0]   empty,
    input  logic [CHANNEL_W-1:0] channel,
    input  logic                 sop,
    input  logic                 eop,
    input  logic                 downstream_ready,
    output logic                 upstream_ready,
    output logic [DATA_W-1:0]    q_data,
    output logic [EMPTY_W-1:0]   q_empty,
    output logic [CHANNEL_W-1:0] q_channel,
    output logic                 q_sop,
    output logic                 q_eop,
    output logic                 q_valid
);

    // Room for a new word whenever the register is empty or being drained this cycle
    assign upstream_ready = !q_valid || downstream_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            q_data    <= '0;
            q_empty   <= '0;
            q_channel <= '0;
            q_sop     <= 1'b0;
            q_eop     <= 1'b0;
            q_valid   <= 1'b0;
        end else if (load) begin
            q_data    <= data;
            q_empty   <= empty;
            q_channel <= channel;
            q_sop     <= sop;
            q_eop     <= eop;
            q_valid   <= 1'b1;
        end else if (downstream_ready) begin
            q_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/ast_width_upconverter.sv
// Avalon-ST width upconverter: packs N narrow beats (first beat in MSBs) into one wide word.
module ast_width_upconverter
    import ast_width_upconverter_pkg::*;
#(
    parameter int DATA_IN_W   = DEF_DATA_IN_W,
    parameter int DATA_OUT_W  = DEF_DATA_OUT_W,
    parameter int CHANNEL_W   = DEF_CHANNEL_W,
    parameter int EMPTY_IN_W  = clog2_min1(DATA_IN_W / 8),
    parameter int EMPTY_OUT_W = clog2_min1(DATA_OUT_W / 8)
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    input  logic                   ast_ready_i
);

    localparam int N          = DATA_OUT_W / DATA_IN_W;
    localparam int CNT_W      = clog2_min1(N);
    localparam int BEAT_BYTES = DATA_IN_W / 8;

    logic [CNT_W-1:0]       beat_cnt;
    logic [CNT_W-1:0]       beat_idx;
    logic [DATA_OUT_W-1:0]  acc;
    logic [DATA_OUT_W-1:0]  word;
    logic [CHANNEL_W-1:0]   chan_reg;
    logic [CHANNEL_W-1:0]   chan_next;
    logic [EMPTY_OUT_W-1:0] empty_next;
    logic                   pkt_open;
    logic                   word_sop;
    logic                   word_sop_next;
    logic                   in_fire;
    logic                   accept;
    logic                   complete;

    assign in_fire       = ast_valid_i && ast_ready_o;
    // Beats outside an open packet are consumed but dropped
    assign accept        = in_fire && (ast_startofpacket_i || pkt_open);
    // A sop always restarts the word, discarding any partial accumulation
    assign beat_idx      = ast_startofpacket_i ? '0 : beat_cnt;
    assign complete      = accept && (ast_endofpacket_i || (beat_idx == CNT_W'(N - 1)));
    assign word_sop_next = ast_startofpacket_i || word_sop;
    assign chan_next     = ast_startofpacket_i ? ast_channel_i : chan_reg;

    // Merge the incoming beat into its lane; a fresh word starts from zero so unused lanes stay 0
    always_comb begin
        word = (beat_idx == '0) ? '0 : acc;
        for (int s = 0; s < N; s++) begin
            if (beat_idx == CNT_W'(s)) begin
                word[DATA_OUT_W-1-s*DATA_IN_W -: DATA_IN_W] = ast_data_i;
            end
        end
    end

    always_comb begin
        empty_next = '0;
        if (ast_endofpacket_i) begin
            empty_next = EMPTY_OUT_W'(int'(ast_empty_i) + (N - 1 - int'(beat_idx)) * BEAT_BYTES);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            beat_cnt <= '0;
            acc      <= '0;
            chan_reg <= '0;
            pkt_open <= 1'b0;
            word_sop <= 1'b0;
        end else if (accept) begin
            chan_reg <= chan_next;
            if (complete) begin
                beat_cnt <= '0;
                word_sop <= 1'b0;
                pkt_open <= !ast_endofpacket_i;
            end else begin
                beat_cnt <= beat_idx + CNT_W'(1);
                acc      <= word;
                word_sop <= word_sop_next;
                pkt_open <= 1'b1;
            end
        end
    end

    ast_upconv_out_reg #(
        .DATA_W    (DATA_OUT_W),
        .EMPTY_W   (EMPTY_OUT_W),
        .CHANNEL_W (CHANNEL_W)
    ) u_out_reg (
        .clk              (clk_i),
        .srst             (srst_i),
        .load             (complete),
        .data             (word),
        .empty            (empty_next),
        .channel          (chan_next),
        .sop              (word_sop_next),
        .eop              (ast_endofpacket_i),
        .downstream_ready (ast_ready_i),
        .upstream_ready   (ast_ready_o),
        .q_data           (ast_data_o),
        .q_empty          (ast_empty_o),
        .q_channel        (ast_channel_o),
        .q_sop            (ast_startofpacket_o),
        .q_eop            (ast_endofpacket_o),
        .q_valid          (ast_valid_o)
    );

endmodule

// File: tb/tb_ast_width_upconverter.sv
// Directed bench for ast_width_upconverter: an N=2 instance for most scenarios plus an N=4 instance.
module tb_ast_width_upconverter;

    localparam int DIN   = 64;
    localparam int DOUT  = 128;
    localparam int N     = DOUT / DIN;
    localparam int CHW   = 10;
    localparam int EIN   = 3;
    localparam int EOUT  = 4;
    localparam int DOUT4 = 256;
    localparam int EOUT4 = 5;

    typedef struct packed {
        logic [DOUT-1:0] data;
        logic [EOUT-1:0] empty;
        logic [CHW-1:0]  channel;
        logic            sop;
        logic            eop;
    } word_t;

    logic clk = 1'b0;
    logic srst;

    logic [DIN-1:0]  data_i;
    logic [EIN-1:0]  empty_i;
    logic            sop_i, eop_i, valid_i;
    logic [CHW-1:0]  chan_i;
    logic            ready_o;
    logic [DOUT-1:0] data_o;
    logic [EOUT-1:0] empty_o;
    logic [CHW-1:0]  chan_o;
    logic            sop_o, eop_o, valid_o;
    logic            ready_i;

    logic [DIN-1:0]   data4_i;
    logic [EIN-1:0]   empty4_i;
    logic             sop4_i, eop4_i, valid4_i;
    logic [CHW-1:0]   chan4_i;
    logic             ready4_o;
    logic [DOUT4-1:0] data4_o;
    logic [EOUT4-1:0] empty4_o;
    logic [CHW-1:0]   chan4_o;
    logic             sop4_o, eop4_o, valid4_o;
    logic             ready4_i;

    int checks = 0;
    int passed = 0;
    int stall_err = 0;

    always #5 clk = ~clk;

    ast_width_upconverter #(
        .DATA_IN_W(DIN), .DATA_OUT_W(DOUT), .CHANNEL_W(CHW), .EMPTY_IN_W(EIN), .EMPTY_OUT_W(EOUT)
    ) dut (
        .clk_i(clk), .srst_i(srst),
        .ast_data_i(data_i), .ast_empty_i(empty_i), .ast_startofpacket_i(sop_i),
        .ast_endofpacket_i(eop_i), .ast_valid_i(valid_i), .ast_channel_i(chan_i),
        .ast_ready_o(ready_o),
        .ast_data_o(data_o), .ast_empty_o(empty_o), .ast_channel_o(chan_o),
        .ast_startofpacket_o(sop_o), .ast_endofpacket_o(eop_o), .ast_valid_o(valid_o),
        .ast_ready_i(ready_i)
    );

    ast_width_upconverter #(
        .DATA_IN_W(DIN), .DATA_OUT_W(DOUT4), .CHANNEL_W(CHW), .EMPTY_IN_W(EIN), .EMPTY_OUT_W(EOUT4)
    ) dut4 (
        .clk_i(clk), .srst_i(srst),
        .ast_data_i(data4_i), .ast_empty_i(empty4_i), .ast_startofpacket_i(sop4_i),
        .ast_endofpacket_i(eop4_i), .ast_valid_i(valid4_i), .ast_channel_i(chan4_i),
        .ast_ready_o(ready4_o),
        .ast_data_o(data4_o), .ast_empty_o(empty4_o), .ast_channel_o(chan4_o),
        .ast_startofpacket_o(sop4_o), .ast_endofpacket_o(eop4_o), .ast_valid_o(valid4_o),
        .ast_ready_i(ready4_i)
    );

    // Output monitor: collects accepted words and flags any change while stalled
    word_t got_q[$];
    word_t cur;
    word_t held;
    logic  held_v = 1'b0;

    assign cur = {data_o, empty_o, chan_o, sop_o, eop_o};

    always @(negedge clk) begin
        if (srst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && (valid_o !== 1'b1 || cur !== held)) stall_err++;
            if (valid_o === 1'b1 && ready_i === 1'b1) got_q.push_back(cur);
            held_v = (valid_o === 1'b1 && ready_i === 1'b0);
            held   = cur;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        srst = 1'b1;
        valid_i = 1'b0;
        valid4_i = 1'b0;
        idle(2);
        srst = 1'b0;
    endtask

    task automatic send_beat(input logic [DIN-1:0] d, input logic s, input logic e,
                             input logic [EIN-1:0] em, input logic [CHW-1:0] ch);
        logic r;
        int   t;
        data_i  = d;
        sop_i   = s;
        eop_i   = e;
        empty_i = em;
        chan_i  = ch;
        valid_i = 1'b1;
        r = 1'b0;
        t = 0;
        while (!r && t < 200) begin
            @(negedge clk);
            r = ready_o;
            @(posedge clk);
            #1;
            t++;
        end
        valid_i = 1'b0;
        if (!r) begin
            checks++;
            $display("[TB] FAIL send_beat_timeout: ready_o=%b after %0d cycles, required 1", r, t);
        end
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b need 0", valid_o); else passed++;
        checks++; if ({sop_o, eop_o} !== 2'b00) $display("[TB] FAIL reset_sop_eop: got %b need 00", {sop_o, eop_o}); else passed++;
        checks++; if (data_o !== '0) $display("[TB] FAIL reset_data: got %h need 0", data_o); else passed++;
        checks++; if ({empty_o, chan_o} !== '0) $display("[TB] FAIL reset_empty_chan: got %h/%h need 0/0", empty_o, chan_o); else passed++;
        checks++; if (ready_o !== 1'b1) $display("[TB] FAIL reset_ready: got %b need 1", ready_o); else passed++;
        checks++; if (valid4_o !== 1'b0) $display("[TB] FAIL reset_valid_n4: got %b need 0", valid4_o); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_four_beats();
        word_t e0, e1;
        bit    ok;
        time   t0, t1;
        got_q.delete();
        ready_i = 1'b1;
        t0 = $time;
        send_beat({8{8'h11}}, 1'b1, 1'b0, 3'd0, 10'h155);
        send_beat({8{8'h22}}, 1'b0, 1'b0, 3'd0, 10'h000);
        send_beat({8{8'h33}}, 1'b0, 1'b0, 3'd0, 10'h000);
        send_beat({8{8'h44}}, 1'b0, 1'b1, 3'd0, 10'h000);
        t1 = $time;
        checks++; if (t1 - t0 != 40) $display("[TB] FAIL four_beats_throughput: took %0t need 40", t1 - t0); else passed++;
        wait_words(2, 50, ok);
        e0 = '0; e0.data = {{8{8'h11}}, {8{8'h22}}}; e0.channel = 10'h155; e0.sop = 1'b1;
        e1 = '0; e1.data = {{8{8'h33}}, {8{8'h44}}}; e1.channel = 10'h155; e1.eop = 1'b1;
        checks++; if (got_q.size() != 2) $display("[TB] FAIL four_beats_count: got %0d need 2", got_q.size()); else passed++;
        if (ok) begin
            checks++; if (got_q[0] !== e0) $display("[TB] FAIL four_beats_word0: got %h need %h", got_q[0], e0); else passed++;
            checks++; if (got_q[1] !== e1) $display("[TB] FAIL four_beats_word1: got %h need %h", got_q[1], e1); else passed++;
        end
    endtask

    task automatic test_partial_eop();
        word_t e0, e1;
        bit    ok;
        got_q.delete();
        send_beat(64'hA1A2A3A4A5A6A7A8, 1'b1, 1'b0, 3'd5, 10'h0F0);
        send_beat(64'hB1B2B3B4B5B6B7B8, 1'b0, 1'b0, 3'd6, 10'h001);
        send_beat(64'hC1C2C3C4C5C6C7C8, 1'b0, 1'b1, 3'd3, 10'h002);
        wait_words(2, 50, ok);
        e0 = '0; e0.data = {64'hA1A2A3A4A5A6A7A8, 64'hB1B2B3B4B5B6B7B8}; e0.channel = 10'h0F0; e0.sop = 1'b1;
        e1 = '0; e1.data = {64'hC1C2C3C4C5C6C7C8, 64'h0}; e1.channel = 10'h0F0; e1.eop = 1'b1; e1.empty = 4'd11;
        checks++; if (!ok) $display("[TB] FAIL partial_eop_count: got %0d need 2", got_q.size()); else passed++;
        if (ok) begin
            checks++; if (got_q[0] !== e0) $display("[TB] FAIL partial_eop_word0: got %h need %h", got_q[0], e0); else passed++;
            checks++; if (got_q[1] !== e1) $display("[TB] FAIL partial_eop_word1: got %h need %h", got_q[1], e1); else passed++;
        end
    endtask

    task automatic test_single_beat();
        word_t e;
        got_q.delete();
        send_beat(64'h0123456789ABCDEF, 1'b1, 1'b1, 3'd2, 10'h3C3);
        @(negedge clk);
        e = '0; e.data = {64'h0123456789ABCDEF, 64'h0}; e.empty = 4'd10; e.channel = 10'h3C3; e.sop = 1'b1; e.eop = 1'b1;
        checks++; if (valid_o !== 1'b1) $display("[TB] FAIL single_latency: valid_o=%b need 1", valid_o); else passed++;
        checks++; if (cur !== e) $display("[TB] FAIL single_word: got %h need %h", cur, e); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat_n4();
        ready4_i = 1'b1;
        data4_i  = 64'hDEADBEEFCAFEF00D;
        sop4_i   = 1'b1;
        eop4_i   = 1'b1;
        empty4_i = 3'd5;
        chan4_i  = 10'h2A5;
        valid4_i = 1'b1;
        @(posedge clk);
        #1;
        valid4_i = 1'b0;
        @(negedge clk);
        checks++; if (valid4_o !== 1'b1) $display("[TB] FAIL n4_valid: got %b need 1", valid4_o); else passed++;
        checks++; if (data4_o !== {64'hDEADBEEFCAFEF00D, 192'h0}) $display("[TB] FAIL n4_data: got %h need %h", data4_o, {64'hDEADBEEFCAFEF00D, 192'h0}); else passed++;
        checks++; if (empty4_o !== 5'd29) $display("[TB] FAIL n4_empty: got %0d need 29", empty4_o); else passed++;
        checks++; if (chan4_o !== 10'h2A5) $display("[TB] FAIL n4_channel: got %h need 2a5", chan4_o); else passed++;
        checks++; if ({sop4_o, eop4_o} !== 2'b11) $display("[TB] FAIL n4_framing: got %b need 11", {sop4_o, eop4_o}); else passed++;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (valid4_o !== 1'b0) $display("[TB] FAIL n4_drained: valid=%b need 0", valid4_o); else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sop_restart();
        word_t e;
        got_q.delete();
        send_beat(64'h5555555555555555, 1'b0, 1'b0, 3'd0, 10'h111);
        send_beat(64'h6666666666666666, 1'b1, 1'b0, 3'd0, 10'h0AA);
        send_beat(64'h7777777777777777, 1'b1, 1'b0, 3'd0, 10'h1BB);
        send_beat(64'h8888888888888888, 1'b0, 1'b1, 3'd4, 10'h3FF);
        idle(6);
        e = '0; e.data = {64'h7777777777777777, 64'h8888888888888888}; e.empty = 4'd4; e.channel = 10'h1BB; e.sop = 1'b1; e.eop = 1'b1;
        checks++; if (got_q.size() != 1) $display("[TB] FAIL restart_count: got %0d need 1", got_q.size()); else passed++;
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0] !== e) $display("[TB] FAIL restart_word: got %h need %h", got_q[0], e); else passed++;
        end
    endtask

    task automatic test_reset_mid_packet();
        got_q.delete();
        send_beat(64'h9999999999999999, 1'b1, 1'b0, 3'd0, 10'h123);
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        checks++; if (ready_o !== 1'b1) $display("[TB] FAIL reset_mid_ready: got %b need 1", ready_o); else passed++;
        @(posedge clk);
        #1;
        send_beat(64'hAAAAAAAAAAAAAAAA, 1'b0, 1'b1, 3'd1, 10'h123);
        idle(6);
        checks++; if (got_q.size() != 0) $display("[TB] FAIL reset_mid_output: got %0d words need 0", got_q.size()); else passed++;
        checks++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_mid_valid: got %b need 0", valid_o); else passed++;
    endtask

    task automatic test_back_to_back_stalls();
        word_t exp_q[$];
        word_t w;
        bit    done;
        bit    ok;
        got_q.delete();
        stall_err = 0;
        done = 1'b0;
        w = '0;
        fork
            begin
                for (int p = 0; p < 10; p++) begin
                    int len;
                    int em;
                    logic [CHW-1:0] ch;
                    len = $urandom_range(1, 5);
                    em  = $urandom_range(0, 7);
                    ch  = CHW'($urandom);
                    for (int i = 0; i < len; i++) begin
                        logic [DIN-1:0] d;
                        int  slot;
                        bit  last;
                        d    = {$urandom, $urandom};
                        slot = i % N;
                        last = (i == len - 1);
                        if (slot == 0) w = '0;
                        w.data[DOUT-1-slot*DIN -: DIN] = d;
                        if (slot == N - 1 || last) begin
                            w.sop     = (i < N);
                            w.eop     = last;
                            w.channel = ch;
                            w.empty   = last ? EOUT'(em + (N - 1 - slot) * (DIN / 8)) : '0;
                            exp_q.push_back(w);
                        end
                        send_beat(d, i == 0, last, last ? EIN'(em) : EIN'($urandom),
                                  (i == 0) ? ch : CHW'($urandom));
                        idle($urandom_range(0, 2));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ready_i = 1'b1;
                    repeat ($urandom_range(1, 4)) begin @(posedge clk); #1; end
                    ready_i = 1'b0;
                    repeat ($urandom_range(0, 10)) begin @(posedge clk); #1; end
                end
                ready_i = 1'b1;
            end
        join
        wait_words(exp_q.size(), 200, ok);
        idle(4);
        checks++; if (got_q.size() != exp_q.size()) $display("[TB] FAIL stream_count: got %0d need %0d", got_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("[TB] FAIL stream_word%0d: got %h need %h", i, got_q[i], exp_q[i]);
            else passed++;
        end
        checks++; if (stall_err != 0) $display("[TB] FAIL stall_stability: %0d changes while stalled, need 0", stall_err); else passed++;
    endtask

    initial begin
        srst     = 1'b1;
        valid_i  = 1'b0;
        data_i   = '0;
        empty_i  = '0;
        sop_i    = 1'b0;
        eop_i    = 1'b0;
        chan_i   = '0;
        ready_i  = 1'b1;
        valid4_i = 1'b0;
        data4_i  = '0;
        empty4_i = '0;
        sop4_i   = 1'b0;
        eop4_i   = 1'b0;
        chan4_i  = '0;
        ready4_i = 1'b1;
        #1;
        test_reset();
        test_four_beats();
        test_partial_eop();
        test_single_beat();
        test_single_beat_n4();
        test_sop_restart();
        test_reset_mid_packet();
        test_back_to_back_stalls();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
